md_zbank_arb: RTL and testbench

MD_ZBANK_ARB -- requirements
Module: md_zbank_arb

---
 rtl/md_zbank_arb_if.sv | 45 ++++
 rtl/md_zbank_arb.sv | 224 ++++++++++++++++++++++
 tb/tb_md_zbank_arb.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/md_zbank_arb_if.sv
// Z80 banked-window and 68k bus-master signal bundle for md_zbank_arb.
// The slave modport is the arbiter side; master is the environment side.
interface md_zbank_arb_if;
    // Z80 side
    logic        bank_wr;
    logic        bank_bit;
    logic        zreq;
    logic        zrw;
    logic [14:0] za;
    logic [7:0]  zd_wr;
    logic        zack;
    logic [7:0]  zd_rd;
    logic        zwait;
    // 68k arbitration
    logic        br_n;
    logic        bg_n;
    logic        bgack_n;
    logic        as_i_n;
    logic        dtack_n;
    // 68k address, strobes and data with hi-Z flags
    logic [22:0] va_o;
    logic        va_d;
    logic        as_o_n;
    logic        uds_o_n;
    logic        lds_o_n;
    logic        rw_o;
    logic        s_d;
    logic [15:0] vd_i;
    logic [15:0] vd_o;
    logic        vd_d;

    modport slave (
        input  bank_wr, bank_bit, zreq, zrw, za, zd_wr,
        input  bg_n, as_i_n, dtack_n, vd_i,
        output zack, zd_rd, zwait, br_n, bgack_n,
        output va_o, va_d, as_o_n, uds_o_n, lds_o_n, rw_o, s_d, vd_o, vd_d
    );

    modport master (
        output bank_wr, bank_bit, zreq, zrw, za, zd_wr,
        output bg_n, as_i_n, dtack_n, vd_i,
        input  zack, zd_rd, zwait, br_n, bgack_n,
        input  va_o, va_d, as_o_n, uds_o_n, lds_o_n, rw_o, s_d, vd_o, vd_d
    );
endinterface

// File: rtl/md_zbank_arb.sv
// Z80 8000h-FFFFh banked window onto the 68k bus: takes the bus via BR/BG/BGACK and runs one cycle.
// Optional MD_ZBANK_TIMEOUT_EN adds a DTACK watchdog and the sticky timeout_err output.
module md_zbank_arb (
    input  logic          MCLK,
    input  logic          ext_reset,
    md_zbank_arb_if.slave bus
`ifdef MD_ZBANK_TIMEOUT_EN
    ,
    output logic          timeout_err
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StGrant,
        StAddr,
        StStrb,
        StWaitd,
        StRel
    } state_e;

    state_e      state_q, state_d;
    logic [8:0]  bank_q, bank_d;
    logic [23:0] addr_q, addr_d;
    logic        zrw_q, zrw_d;
    logic [7:0]  zd_q, zd_d;

    logic        zack_q, zack_d;
    logic [7:0]  zd_rd_q, zd_rd_d;
    logic        zwait_q, zwait_d;
    logic        br_n_q, br_n_d;
    logic        bgack_n_q, bgack_n_d;
    logic        va_d_q, va_d_d;
    logic        s_d_q, s_d_d;
    logic        vd_d_q, vd_d_d;
    logic        as_n_q, as_n_d;
    logic        uds_n_q, uds_n_d;
    logic        lds_n_q, lds_n_d;
    logic        rw_q, rw_d;

    logic        timed_out;

`ifdef MD_ZBANK_TIMEOUT_EN
    logic [7:0] wd_q, wd_d;
    logic       to_err_q, to_err_d;

    // Counter is 0 in the first STRB cycle, so the 255th DTACK-less cycle sees 254.
    assign timed_out = ((state_q == StStrb) || (state_q == StWaitd)) &&
                       bus.dtack_n && (wd_q == 8'd254);

    always_comb begin
        wd_d     = wd_q;
        to_err_d = to_err_q | timed_out;
        if (state_q == StAddr) begin
            wd_d = 8'd0;
        end else if ((state_q == StStrb) || (state_q == StWaitd)) begin
            wd_d = wd_q + 8'd1;
        end
    end

    always_ff @(posedge MCLK or posedge ext_reset) begin
        if (ext_reset) begin
            wd_q     <= 8'd0;
            to_err_q <= 1'b0;
        end else begin
            wd_q     <= wd_d;
            to_err_q <= to_err_d;
        end
    end

    assign timeout_err = to_err_q;
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        addr_d    = addr_q;
        zrw_d     = zrw_q;
        zd_d      = zd_q;
        zack_d    = 1'b0;
        zd_rd_d   = zd_rd_q;
        zwait_d   = zwait_q;
        br_n_d    = br_n_q;
        bgack_n_d = bgack_n_q;
        va_d_d    = va_d_q;
        s_d_d     = s_d_q;
        vd_d_d    = vd_d_q;
        as_n_d    = as_n_q;
        uds_n_d   = uds_n_q;
        lds_n_d   = lds_n_q;
        rw_d      = rw_q;

        if (bus.bank_wr) begin
            bank_d = {bus.bank_bit, bank_q[8:1]};
        end

        case (state_q)
            StIdle: begin
                // zack_q high marks the completion cycle; no new access starts there.
                if (bus.zreq && !zack_q) begin
                    addr_d  = {bank_q, bus.za};
                    zrw_d   = bus.zrw;
                    zd_d    = bus.zd_wr;
                    br_n_d  = 1'b0;
                    zwait_d = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (!bus.bg_n && bus.as_i_n) begin
                    br_n_d    = 1'b1;
                    bgack_n_d = 1'b0;
                    va_d_d    = 1'b0;
                    s_d_d     = 1'b0;
                    rw_d      = zrw_q;
                    state_d   = StGrant;
                end
            end
            StGrant: begin
                as_n_d  = 1'b0;
                uds_n_d = addr_q[0];
                lds_n_d = ~addr_q[0];
                if (!zrw_q) begin
                    vd_d_d = 1'b0;
                end
                state_d = StAddr;
            end
            StAddr: begin
                state_d = StStrb;
            end
            StStrb, StWaitd: begin
                if (!bus.dtack_n) begin
                    if (zrw_q) begin
                        zd_rd_d = addr_q[0] ? bus.vd_i[7:0] : bus.vd_i[15:8];
                    end
                    as_n_d  = 1'b1;
                    uds_n_d = 1'b1;
                    lds_n_d = 1'b1;
                    state_d = StRel;
                end else if (timed_out) begin
                    zd_rd_d = 8'hFF;
                    as_n_d  = 1'b1;
                    uds_n_d = 1'b1;
                    lds_n_d = 1'b1;
                    state_d = StRel;
                end else begin
                    state_d = StWaitd;
                end
            end
            StRel: begin
                va_d_d    = 1'b1;
                s_d_d     = 1'b1;
                vd_d_d    = 1'b1;
                bgack_n_d = 1'b1;
                rw_d      = 1'b1;
                zwait_d   = 1'b0;
                zack_d    = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge MCLK or posedge ext_reset) begin
        if (ext_reset) begin
            state_q   <= StIdle;
            bank_q    <= 9'd0;
            addr_q    <= 24'd0;
            zrw_q     <= 1'b1;
            zd_q      <= 8'd0;
            zack_q    <= 1'b0;
            zd_rd_q   <= 8'hFF;
            zwait_q   <= 1'b0;
            br_n_q    <= 1'b1;
            bgack_n_q <= 1'b1;
            va_d_q    <= 1'b1;
            s_d_q     <= 1'b1;
            vd_d_q    <= 1'b1;
            as_n_q    <= 1'b1;
            uds_n_q   <= 1'b1;
            lds_n_q   <= 1'b1;
            rw_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            addr_q    <= addr_d;
            zrw_q     <= zrw_d;
            zd_q      <= zd_d;
            zack_q    <= zack_d;
            zd_rd_q   <= zd_rd_d;
            zwait_q   <= zwait_d;
            br_n_q    <= br_n_d;
            bgack_n_q <= bgack_n_d;
            va_d_q    <= va_d_d;
            s_d_q     <= s_d_d;
            vd_d_q    <= vd_d_d;
            as_n_q    <= as_n_d;
            uds_n_q   <= uds_n_d;
            lds_n_q   <= lds_n_d;
            rw_q      <= rw_d;
        end
    end

    assign bus.zack    = zack_q;
    assign bus.zd_rd   = zd_rd_q;
    assign bus.zwait   = zwait_q;
    assign bus.br_n    = br_n_q;
    assign bus.bgack_n = bgack_n_q;
    assign bus.va_o    = addr_q[23:1];
    assign bus.va_d    = va_d_q;
    assign bus.s_d     = s_d_q;
    assign bus.as_o_n  = as_n_q;
    assign bus.uds_o_n = uds_n_q;
    assign bus.lds_o_n = lds_n_q;
    assign bus.rw_o    = rw_q;
    assign bus.vd_o    = {zd_q, zd_q};
    assign bus.vd_d    = vd_d_q;

endmodule

// File: tb/tb_md_zbank_arb.sv
// Directed bench for md_zbank_arb (default build): bank shifting, read/write cycles,
// arbitration corner cases and reset in mid-access.
module tb_md_zbank_arb;

    logic MCLK = 1'b0;
    logic ext_reset;
    int   checks = 0;
    int   errors = 0;
    int   zack_cnt = 0;
    int   z0;

    md_zbank_arb_if bus ();

    md_zbank_arb dut (
        .MCLK      (MCLK),
        .ext_reset (ext_reset),
        .bus       (bus)
    );

    always #5 MCLK = ~MCLK;

    always @(posedge MCLK) begin
        if (bus.zack === 1'b1) zack_cnt <= zack_cnt + 1;
    end

    task automatic tick;
        @(posedge MCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".br_n"}, 32'(bus.br_n), 32'd1);
        chk({tag, ".bgack_n"}, 32'(bus.bgack_n), 32'd1);
        chk({tag, ".strobes"}, 32'({bus.as_o_n, bus.uds_o_n, bus.lds_o_n, bus.rw_o}), 32'hF);
        chk({tag, ".hiz"}, 32'({bus.va_d, bus.s_d, bus.vd_d}), 32'h7);
        chk({tag, ".zack_zwait"}, 32'({bus.zack, bus.zwait}), 32'h0);
        chk({tag, ".zd_rd"}, 32'(bus.zd_rd), 32'hFF);
    endtask

    initial begin
        logic [8:0] seq;
        seq = 9'b1_0000_0001;
        bus.bank_wr  = 1'b0;
        bus.bank_bit = 1'b0;
        bus.zreq     = 1'b0;
        bus.zrw      = 1'b1;
        bus.za       = 15'd0;
        bus.zd_wr    = 8'd0;
        bus.bg_n     = 1'b1;
        bus.as_i_n   = 1'b1;
        bus.dtack_n  = 1'b1;
        bus.vd_i     = 16'd0;
        ext_reset    = 1'b1;
        #2;
        chk_idle_outputs("reset");
        tick();
        tick();
        ext_reset = 1'b0;
        tick();

        // Read at bank 0x101, za 1234h -> byte 0x809234, word address 0x40491A, UDS only
        for (int i = 0; i < 9; i++) begin
            bus.bank_wr  = 1'b1;
            bus.bank_bit = seq[i];
            tick();
        end
        bus.bank_wr = 1'b0;
        z0 = zack_cnt;
        bus.zreq = 1'b1;
        bus.zrw  = 1'b1;
        bus.za   = 15'h1234;
        tick();
        chk("rd.req_br_n", 32'(bus.br_n), 32'd0);
        chk("rd.req_zwait", 32'(bus.zwait), 32'd1);
        bus.zreq = 1'b0;
        tick();
        tick();
        chk("rd.req_hold_br_n", 32'(bus.br_n), 32'd0);
        chk("rd.req_hold_bgack_n", 32'(bus.bgack_n), 32'd1);
        bus.bg_n = 1'b0;
        tick();
        chk("rd.grant_bgack_br", 32'({bus.bgack_n, bus.br_n}), 32'h1);
        chk("rd.grant_va_o", 32'(bus.va_o), 32'h40491A);
        chk("rd.grant_hiz", 32'({bus.va_d, bus.s_d}), 32'h0);
        chk("rd.grant_strobes", 32'({bus.as_o_n, bus.uds_o_n, bus.lds_o_n, bus.rw_o}), 32'hF);
        tick();
        chk("rd.addr_strobes", 32'({bus.as_o_n, bus.uds_o_n, bus.lds_o_n, bus.rw_o}), 32'h3);
        chk("rd.addr_vd_d", 32'(bus.vd_d), 32'd1);
        tick();
        tick();
        chk("rd.waitd_as", 32'(bus.as_o_n), 32'd0);
        bus.dtack_n = 1'b0;
        bus.vd_i    = 16'hC35A;
        tick();
        chk("rd.rel_zd_rd", 32'(bus.zd_rd), 32'hC3);
        chk("rd.rel_strobes", 32'({bus.as_o_n, bus.uds_o_n, bus.lds_o_n}), 32'h7);
        chk("rd.rel_zack", 32'({bus.zack, bus.zwait}), 32'h1);
        bus.dtack_n = 1'b1;
        tick();
        chk("rd.done_zack", 32'({bus.zack, bus.zwait}), 32'h2);
        chk("rd.done_hiz", 32'({bus.va_d, bus.s_d, bus.vd_d, bus.bgack_n}), 32'hF);
        tick();
        chk("rd.zack_count", 32'(zack_cnt - z0), 32'd1);

        // Write A5h at odd address: LDS only, both bytes carry the data
        bus.zreq  = 1'b1;
        bus.zrw   = 1'b0;
        bus.za    = 15'h0001;
        bus.zd_wr = 8'hA5;
        tick();
        bus.zreq = 1'b0;
        tick();
        chk("wr.grant_rw", 32'(bus.rw_o), 32'd0);
        tick();
        chk("wr.addr_vd_o", 32'(bus.vd_o), 32'hA5A5);
        chk("wr.addr_vd_d", 32'(bus.vd_d), 32'd0);
        chk("wr.addr_strobes", 32'({bus.as_o_n, bus.uds_o_n, bus.lds_o_n, bus.rw_o}), 32'h4);
        bus.dtack_n = 1'b0;
        tick();
        chk("wr.strb_rw", 32'(bus.rw_o), 32'd0);
        tick();
        bus.dtack_n = 1'b1;
        tick();
        chk("wr.done_zack", 32'(bus.zack), 32'd1);

        // zreq held during the zack cycle is refused; bank_wr with the accepted zreq
        bus.zreq = 1'b1;
        bus.zrw  = 1'b1;
        bus.za   = 15'h0002;
        tick();
        chk("b2b.refused_br_n", 32'(bus.br_n), 32'd1);
        bus.bank_wr  = 1'b1;
        bus.bank_bit = 1'b0;
        tick();
        chk("bk.accept_br_n", 32'(bus.br_n), 32'd0);
        bus.zreq    = 1'b0;
        bus.bank_wr = 1'b0;
        tick();
        chk("bk.old_bank_va_o", 32'(bus.va_o), 32'h404001);
        bus.dtack_n = 1'b0;
        tick();
        tick();
        tick();
        bus.dtack_n = 1'b1;
        tick();
        tick();
        bus.zreq = 1'b1;
        tick();
        bus.zreq = 1'b0;
        tick();
        chk("bk.new_bank_va_o", 32'(bus.va_o), 32'h200001);
        bus.dtack_n = 1'b0;
        tick();
        tick();
        tick();
        bus.dtack_n = 1'b1;
        tick();
        tick();

        // Grant while another master still drives AS
        bus.as_i_n = 1'b0;
        bus.zreq   = 1'b1;
        bus.za     = 15'h0003;
        tick();
        bus.zreq = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("as_busy.held", 32'({bus.br_n, bus.bgack_n}), 32'h1);
        end
        bus.as_i_n = 1'b1;
        tick();
        chk("as_busy.grant", 32'({bus.br_n, bus.bgack_n}), 32'h2);
        bus.dtack_n = 1'b0;
        tick();
        tick();
        tick();
        bus.dtack_n = 1'b1;
        tick();
        tick();

        // Reset during a write stalled in WAITD
        bus.zreq  = 1'b1;
        bus.zrw   = 1'b0;
        bus.za    = 15'h0006;
        bus.zd_wr = 8'h3C;
        tick();
        bus.zreq = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("rst.waitd_vd_d", 32'(bus.vd_d), 32'd0);
        z0 = zack_cnt;
        #2;
        ext_reset = 1'b1;
        #1;
        chk_idle_outputs("rst.mid");
        #1;
        ext_reset = 1'b0;
        tick();
        tick();
        tick();
        chk("rst.no_zack", 32'(zack_cnt - z0), 32'd0);
        bus.zreq = 1'b1;
        bus.zrw  = 1'b1;
        bus.za   = 15'h0004;
        tick();
        bus.zreq = 1'b0;
        tick();
        chk("rst.bank_cleared_va_o", 32'(bus.va_o), 32'h000002);
        bus.dtack_n = 1'b0;
        tick();
        tick();
        tick();
        bus.dtack_n = 1'b1;
        tick();
        chk("rst.final_zack", 32'(bus.zack), 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
